// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-select codes, SREG bit positions and
// the writeback FSM state type. Also used by the ALU core and decoder.
package alu_pkg;

  localparam int REG_ADDR_W_DEF = 4;

  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_SUB = 4'd1;
  localparam logic [3:0] FUNC_AND = 4'd2;
  localparam logic [3:0] FUNC_MUL = 4'd3;
  localparam logic [3:0] FUNC_OR  = 4'd4;
  localparam logic [3:0] FUNC_XOR = 4'd5;
  localparam logic [3:0] FUNC_CMP = 4'd6;

  localparam int SREG_C = 0;
  localparam int SREG_Z = 1;
  localparam int SREG_N = 2;
  localparam int SREG_V = 3;

  typedef enum logic {
    WB_IDLE   = 1'b0,
    WB_MUL_HI = 1'b1
  } wb_state_e;

  // Bits selected by mask take the new flag value, the rest keep the old one.
  function automatic logic [3:0] merge_flags(input logic [3:0] oldFlags,
                                             input logic [3:0] newFlags,
                                             input logic [3:0] mask);
    return (oldFlags & ~mask) | (newFlags & mask);
  endfunction

endpackage

// File: rtl/alu_writeback_regfile_2r1w.sv
// General-purpose register array: one write port, two combinational read
// ports. A read that hits the address being written this cycle returns the
// incoming data so the ALU sees the value without waiting a cycle.
module regfile_2r1w #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [7:0]        rdata_a_o,
  output logic [7:0]        rdata_b_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] mem_q [DEPTH];

  // Storage: cleared by reset, otherwise one write per clock when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports with write-through bypass; each port checks independently.
  always_comb begin
    rdata_a_o = mem_q[raddr_a_i];
    rdata_b_o = mem_q[raddr_b_i];
    if (we_i && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end
    if (we_i && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: commits results into the register file and SREG.
// Multiplies write the low byte to the even register of a pair on accept
// and the high byte to the odd register one cycle later, stalling issue
// for that extra cycle.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int         REG_ADDR_W = REG_ADDR_W_DEF,
  parameter logic [3:0] MUL_CODE   = FUNC_MUL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            func_sel,
  input  logic [REG_ADDR_W-1:0] dest_addr,
  input  logic                  wr_en,
  input  logic [7:0]            result,
  input  logic [7:0]            mul_high,
  input  logic [3:0]            flags,
  input  logic [3:0]            flag_mask,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [7:0]            rd_data_a,
  output logic [7:0]            rd_data_b,
  output logic [3:0]            sreg,
  output logic                  busy
);

  wb_state_e             state_q, state_d;
  logic [REG_ADDR_W-1:0] hiAddr_q, hiAddr_d;
  logic [7:0]            hiData_q, hiData_d;
  logic                  hiWe_q, hiWe_d;
  logic [3:0]            sreg_q;

  logic                  accept;
  logic                  isMul;
  logic [REG_ADDR_W-1:0] pairEven;
  logic [REG_ADDR_W-1:0] pairOdd;

  logic                  wrEn;
  logic [REG_ADDR_W-1:0] wrAddr;
  logic [7:0]            wrData;

  // Ready depends only on state so there is no path from in_valid.
  assign in_ready = (state_q == WB_IDLE);
  assign busy     = (state_q == WB_MUL_HI);
  assign accept   = in_valid & in_ready;
  assign isMul    = (func_sel == MUL_CODE);
  assign pairEven = {dest_addr[REG_ADDR_W-1:1], 1'b0};
  assign pairOdd  = {dest_addr[REG_ADDR_W-1:1], 1'b1};
  assign sreg     = sreg_q;

  // Next state and the single register-file write port selection.
  always_comb begin
    state_d  = state_q;
    hiAddr_d = hiAddr_q;
    hiData_d = hiData_q;
    hiWe_d   = hiWe_q;
    wrEn     = 1'b0;
    wrAddr   = dest_addr;
    wrData   = result;
    case (state_q)
      WB_IDLE: begin
        if (accept) begin
          wrEn = wr_en;
          if (isMul) begin
            wrAddr   = pairEven;
            hiAddr_d = pairOdd;
            hiData_d = mul_high;
            hiWe_d   = wr_en;
            state_d  = WB_MUL_HI;
          end
        end
      end
      WB_MUL_HI: begin
        wrEn    = hiWe_q;
        wrAddr  = hiAddr_q;
        wrData  = hiData_q;
        state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
    if (rst) begin
      wrEn = 1'b0;
    end
  end

  // FSM, pending high-byte latch and SREG; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WB_IDLE;
      hiAddr_q <= '0;
      hiData_q <= 8'h00;
      hiWe_q   <= 1'b0;
      sreg_q   <= 4'b0000;
    end else begin
      state_q  <= state_d;
      hiAddr_q <= hiAddr_d;
      hiData_q <= hiData_d;
      hiWe_q   <= hiWe_d;
      if (accept) begin
        sreg_q <= merge_flags(sreg_q, flags, flag_mask);
      end
    end
  end

  regfile_2r1w #(
    .ADDR_W(REG_ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wrEn),
    .waddr_i  (wrAddr),
    .wdata_i  (wrData),
    .raddr_a_i(rd_addr_a),
    .raddr_b_i(rd_addr_b),
    .rdata_a_o(rd_data_a),
    .rdata_b_o(rd_data_b)
  );

endmodule
